// File: rtl/kgp_shift_pkg.sv
// Shared types and constants for the serial shift unit and the shamt narrowing stage.
package kgp_shift_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHW   = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/shamt_narrow.sv
// Combinational inverse of the shamt zero-extension: WIDTH-bit amount to an SHW-bit count,
// flagging amounts of WIDTH or more as saturated (count forced to 0).
module shamt_narrow
  import kgp_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic [WIDTH-1:0] shamt_i,
  output logic [SHW-1:0]   count_o,
  output logic             sat_o
);

  assign sat_o   = |shamt_i[WIDTH-1:SHW];
  assign count_o = sat_o ? '0 : shamt_i[SHW-1:0];

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle SLL/SRL/SRA unit: done pulses n+1 cycles after start (1 for n=0 or saturated);
// start is only sampled in IDLE. SERIAL_SHIFTER_NIBBLE_EN enables 4-bit steps while count >= 4.
module serial_shifter
  import kgp_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] shamt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   count_q;
  logic [1:0]       op_q;

  logic [SHW-1:0]   nar_count;
  logic             nar_sat;
  logic [SHW-1:0]   step;
  logic [SHW-1:0]   count_dec;
  logic [WIDTH-1:0] shifted_d;
  logic [WIDTH-1:0] sat_fill_d;

  shamt_narrow #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_narrow (
    .shamt_i (shamt_in),
    .count_o (nar_count),
    .sat_o   (nar_sat)
  );

`ifdef SERIAL_SHIFTER_NIBBLE_EN
  assign step = (count_q >= SHW'(4)) ? SHW'(4) : SHW'(1);
`else
  assign step = SHW'(1);
`endif

  assign count_dec = count_q - step;

  // Reserved op encoding falls through to a logical right shift.
  always_comb begin
    shifted_d = work_q >> step;
    case (op_q)
      OP_SLL:  shifted_d = work_q << step;
      OP_SRA:  shifted_d = $signed(work_q) >>> step;
      default: shifted_d = work_q >> step;
    endcase
  end

  assign sat_fill_d = (op == OP_SRA) ? {WIDTH{data_in[WIDTH-1]}} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= OP_SLL;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            work_q  <= data_in;
            count_q <= nar_count;
            if (nar_sat) begin
              result_q <= sat_fill_d;
              done_q   <= 1'b1;
              state_q  <= FIN;
            end else if (nar_count == '0) begin
              result_q <= data_in;
              done_q   <= 1'b1;
              state_q  <= FIN;
            end else begin
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q  <= shifted_d;
          count_q <= count_dec;
          // Result and done are registered together so done always qualifies the new result.
          if (count_dec == '0) begin
            result_q <= shifted_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed self-checking bench for serial_shifter; expected latency follows the build macro.
module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] shamt_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_shifter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt_in (shamt_in),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  function automatic int exp_lat(input int n);
    if (n == 0) return 1;
`ifdef SERIAL_SHIFTER_NIBBLE_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  function automatic int exp_busy(input int n);
    return exp_lat(n) - 1;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [31:0] s);
    @(negedge clk);
    op = o; data_in = d; shamt_in = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'b00; data_in = 32'hA5A5_5A5A; shamt_in = 32'h3;
  endtask

  task automatic wait_done(input int limit, output int lat, output int bcnt, output bit ok);
    lat = 0; bcnt = 0; ok = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int lat, bc; bit ok;
    rst = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; shamt_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want %h", result, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    wait_done(8, lat, bc, ok);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL idle_no_done: got done at cycle %0d want none", lat); end
  endtask

  task automatic test_sll;
    int lat, bc; bit ok;
    issue(2'b00, 32'h0000_0001, 32'h0000_0004);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat != exp_lat(4)) begin errors++; $display("FAIL sll_latency: got %0d (ok=%0b) want %0d", lat, ok, exp_lat(4)); end
    checks++; if (bc != exp_busy(4)) begin errors++; $display("FAIL sll_busy_cycles: got %0d want %0d", bc, exp_busy(4)); end
    checks++; if (result !== 32'h0000_0010) begin errors++; $display("FAIL sll_result: got %h want %h", result, 32'h10); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sll_done_single: got %b want 0", done); end
    checks++; if (result !== 32'h0000_0010) begin errors++; $display("FAIL sll_result_hold: got %h want %h", result, 32'h10); end
  endtask

  task automatic test_sra_sign;
    int lat, bc; bit ok;
    issue(2'b10, 32'h8000_0000, 32'd31);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat != exp_lat(31)) begin errors++; $display("FAIL sra31_latency: got %0d (ok=%0b) want %0d", lat, ok, exp_lat(31)); end
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31_result: got %h want %h", result, 32'hFFFF_FFFF); end
    issue(2'b01, 32'h8000_0000, 32'd31);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat != exp_lat(31)) begin errors++; $display("FAIL srl31_latency: got %0d (ok=%0b) want %0d", lat, ok, exp_lat(31)); end
    checks++; if (result !== 32'h0000_0001) begin errors++; $display("FAIL srl31_result: got %h want %h", result, 32'h1); end
    issue(2'b10, 32'hF000_0000, 32'd5);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || result !== 32'hFF80_0000) begin errors++; $display("FAIL sra5_result: got %h (ok=%0b) want %h", result, ok, 32'hFF80_0000); end
    issue(2'b11, 32'h8000_0000, 32'd4);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || result !== 32'h0800_0000) begin errors++; $display("FAIL reserved_op_result: got %h (ok=%0b) want %h", result, ok, 32'h0800_0000); end
  endtask

  task automatic test_saturation;
    int lat, bc; bit ok;
    issue(2'b10, 32'h8000_1234, 32'h0000_0020);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL sat_sra_latency: got %0d (ok=%0b) want 1", lat, ok); end
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_sra_result: got %h want %h", result, 32'hFFFF_FFFF); end
    issue(2'b00, 32'h8000_1234, 32'h0000_0020);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL sat_sll_latency: got %0d (ok=%0b) want 1", lat, ok); end
    checks++; if (result !== 32'h0000_0000) begin errors++; $display("FAIL sat_sll_result: got %h want %h", result, 32'h0); end
    issue(2'b10, 32'h7000_0000, 32'hFFFF_FFFF);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || result !== 32'h0000_0000) begin errors++; $display("FAIL sat_sra_pos_result: got %h (ok=%0b) want %h", result, ok, 32'h0); end
  endtask

  task automatic test_zero_and_ignored;
    int lat, bc; bit ok;
    issue(2'b00, 32'hDEAD_BEEF, 32'h0);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL zero_latency: got %0d (ok=%0b) want 1", lat, ok); end
    checks++; if (result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_result: got %h want %h", result, 32'hDEAD_BEEF); end
    // A start arriving mid-shift must not disturb the operation already in flight.
    issue(2'b00, 32'h0000_0005, 32'd10);
    @(negedge clk); @(negedge clk);
    op = 2'b01; data_in = 32'h1; shamt_in = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat + 3 != exp_lat(10)) begin errors++; $display("FAIL ignored_start_latency: got %0d (ok=%0b) want %0d", lat + 3, ok, exp_lat(10)); end
    checks++; if (result !== 32'h0000_1400) begin errors++; $display("FAIL ignored_start_result: got %h want %h", result, 32'h1400); end
    // A start held during the FIN cycle is ignored as well.
    op = 2'b01; data_in = 32'h1; shamt_in = 32'h0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(10, lat, bc, ok);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL fin_start_ignored: got done at cycle %0d want none", lat); end
    checks++; if (result !== 32'h0000_1400) begin errors++; $display("FAIL fin_start_result: got %h want %h", result, 32'h1400); end
  endtask

  task automatic test_reset_mid;
    int lat, bc; bit ok;
    issue(2'b00, 32'h0000_0001, 32'd20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want %h", result, 32'h0); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done(30, lat, bc, ok);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got done at cycle %0d want none", lat); end
    issue(2'b01, 32'h0000_0100, 32'd8);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat != exp_lat(8)) begin errors++; $display("FAIL post_rst_latency: got %0d (ok=%0b) want %0d", lat, ok, exp_lat(8)); end
    checks++; if (result !== 32'h0000_0001) begin errors++; $display("FAIL post_rst_result: got %h want %h", result, 32'h1); end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit ok;
    issue(2'b00, 32'h0000_0003, 32'd9);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || lat != exp_lat(9)) begin errors++; $display("FAIL shamt9_latency: got %0d (ok=%0b) want %0d", lat, ok, exp_lat(9)); end
    checks++; if (result !== 32'h0000_0600) begin errors++; $display("FAIL shamt9_result: got %h want %h", result, 32'h600); end
    issue(2'b10, 32'h8765_4321, 32'd16);
    wait_done(60, lat, bc, ok);
    checks++; if (!ok || result !== 32'hFFFF_8765) begin errors++; $display("FAIL b2b_sra16_result: got %h (ok=%0b) want %h", result, ok, 32'hFFFF_8765); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sll();
    test_sra_sign();
    test_saturation();
    test_zero_and_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
